// File: rtl/pingpong_buf_if.sv
// pingpong_buf_if: write/read handshake and bank/pointer outputs of the ping-pong buffer
interface pingpong_buf_if #(parameter int size = 8);
    logic [size-1:0] din;
    logic            wr_en;
    logic            rd_en;
    logic [size-1:0] a;
    logic [size-1:0] b;
    logic            sel;
    logic            empty;
    logic            full;
    logic            ovf;
    logic            udf;
    modport master (output din, wr_en, rd_en, input a, b, sel, empty, full, ovf, udf);
    modport slave  (input din, wr_en, rd_en, output a, b, sel, empty, full, ovf, udf);
endinterface

// File: rtl/pingpong_buf.sv
// pingpong_buf: two-bank ping-pong FIFO driving a 2:1 mux so its output shows the oldest unread word
module pingpong_buf #(parameter int size = 8) (
    input logic clk,
    input logic rst_n,
    pingpong_buf_if.slave bus
);
    typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;
    state_t state, next_state;
    logic [size-1:0] bank0, bank1;
    logic wr_ptr, rd_ptr, ovf, udf, wr_ok, rd_ok;
    // when full, a write only fits if the head bank is being released in the same cycle
    always_comb begin
        rd_ok = bus.rd_en && state != S_EMPTY;
        wr_ok = bus.wr_en && (state != S_FULL || bus.rd_en);
        next_state = state;
        case (state)
            S_EMPTY: next_state = wr_ok ? S_ONE : S_EMPTY;
            S_ONE:   next_state = (wr_ok && !rd_ok) ? S_FULL : (rd_ok && !wr_ok) ? S_EMPTY : S_ONE;
            S_FULL:  next_state = (rd_ok && !wr_ok) ? S_ONE : S_FULL;
            default: next_state = S_EMPTY;
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_EMPTY;
            bank0  <= '0;
            bank1  <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            ovf    <= 1'b0;
            udf    <= 1'b0;
        end else begin
            state <= next_state;
            if (wr_ok) begin
                if (wr_ptr) bank1 <= bus.din;
                else bank0 <= bus.din;
                wr_ptr <= ~wr_ptr;
            end
            if (rd_ok) rd_ptr <= ~rd_ptr;
            ovf <= ovf | (bus.wr_en && !wr_ok);
            udf <= udf | (bus.rd_en && state == S_EMPTY);
        end
    end
    assign bus.a     = bank0;
    assign bus.b     = bank1;
    assign bus.sel   = rd_ptr;
    assign bus.empty = state == S_EMPTY;
    assign bus.full  = state == S_FULL;
    assign bus.ovf   = ovf;
    assign bus.udf   = udf;
endmodule

// File: tb/tb_pingpong_buf.sv
// tb_pingpong_buf: directed and random stimulus checked each cycle against a queue-based model
module tb_pingpong_buf;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0;
    int errors = 0;
    int checks = 0;
    pingpong_buf_if #(.size(8)) bus ();
    pingpong_buf #(.size(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    wire [7:0] mux_out = bus.sel ? bus.b : bus.a;

    // model: a queue of unread words plus the last value written to each bank
    logic [7:0] q[$];
    logic [7:0] m_bank[2] = '{8'h00, 8'h00};
    logic m_wp = 1'b0, m_rp = 1'b0, m_ovf = 1'b0, m_udf = 1'b0;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            m_bank = '{8'h00, 8'h00};
            m_wp = 1'b0; m_rp = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            automatic bit rd = bus.rd_en && q.size() > 0;
            automatic bit wr = bus.wr_en && (q.size() < 2 || rd);
            if (bus.rd_en && q.size() == 0) m_udf = 1'b1;
            if (bus.wr_en && !wr) m_ovf = 1'b1;
            if (rd) begin
                void'(q.pop_front());
                m_rp = ~m_rp;
            end
            if (wr) begin
                m_bank[m_wp] = bus.din;
                q.push_back(bus.din);
                m_wp = ~m_wp;
            end
        end
    end

    always @(negedge clk) begin
        if (en) begin
            chk("a", bus.a, m_bank[0]);
            chk("b", bus.b, m_bank[1]);
            chk("sel", bus.sel, m_rp);
            chk("empty", bus.empty, q.size() == 0);
            chk("full", bus.full, q.size() == 2);
            chk("ovf", bus.ovf, m_ovf);
            chk("udf", bus.udf, m_udf);
            if (q.size() > 0) chk("head", mux_out, q[0]);
        end
    end

    task automatic cyc(input logic w, input logic r, input logic [7:0] d);
        bus.wr_en = w; bus.rd_en = r; bus.din = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset();
        chk("rst_a", bus.a, 8'h00);
        chk("rst_b", bus.b, 8'h00);
        chk("rst_sel", bus.sel, 1'b0);
        chk("rst_empty", bus.empty, 1'b1);
        chk("rst_full", bus.full, 1'b0);
        chk("rst_ovf", bus.ovf, 1'b0);
        chk("rst_udf", bus.udf, 1'b0);
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.din = 8'h00;
        rst_n = 1'b0;
        cyc(1, 0, 8'hFF);
        en = 1'b1;
        cyc(1, 0, 8'hFF);
        rst_n = 1'b1;
        chk_reset();
        cyc(1, 0, 8'h11);
        cyc(1, 0, 8'h22);
        chk("fill_a", bus.a, 8'h11);
        chk("fill_b", bus.b, 8'h22);
        chk("fill_sel", bus.sel, 1'b0);
        chk("fill_full", bus.full, 1'b1);
        cyc(1, 0, 8'h33);
        chk("drop_ovf", bus.ovf, 1'b1);
        chk("drop_a", bus.a, 8'h11);
        chk("drop_b", bus.b, 8'h22);
        cyc(0, 1, 8'h00);
        chk("drain1_sel", bus.sel, 1'b1);
        chk("drain1_empty", bus.empty, 1'b0);
        chk("drain1_full", bus.full, 1'b0);
        cyc(0, 1, 8'h00);
        chk("drain2_empty", bus.empty, 1'b1);
        cyc(0, 1, 8'h00);
        chk("udf", bus.udf, 1'b1);
        chk("udf_sel", bus.sel, 1'b0);
        rst_n = 1'b0;
        cyc(0, 0, 8'h00);
        rst_n = 1'b1;
        cyc(1, 0, 8'h11);
        cyc(1, 0, 8'h22);
        cyc(1, 1, 8'h44);
        chk("wr_a", bus.a, 8'h44);
        chk("wr_b", bus.b, 8'h22);
        chk("wr_sel", bus.sel, 1'b1);
        chk("wr_full", bus.full, 1'b1);
        chk("wr_ovf", bus.ovf, 1'b0);
        rst_n = 1'b0;
        cyc(0, 0, 8'h00);
        rst_n = 1'b1;
        chk_reset();
        cyc(1, 0, 8'hAA);
        chk("aa_a", bus.a, 8'hAA);
        chk("aa_head", mux_out, 8'hAA);
        for (int i = 1; i <= 6; i++) begin
            cyc(1, 1, 8'(i));
            chk("stream_head", mux_out, 32'(i));
            chk("stream_one", {bus.empty, bus.full}, 2'b00);
        end
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            cyc(1'($urandom), 1'($urandom), 8'($urandom));
        end
        en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
